// File: rtl/rvv_backend_div_pkg.sv
// Shared types and constants for the SEW=8 iterative divider.
package rvv_backend_div_pkg;

    localparam int DIV8_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [DIV8_W-1:0] dividend;
        logic              dividend_is_signed;
        logic [DIV8_W-1:0] divisor;
        logic              divisor_is_signed;
    } div8_req_t;

endpackage

// File: rtl/rvv_backend_div_unit_div8_step.sv
// One restoring-division iteration on a 9-bit partial remainder.
module rvv_backend_div_unit_div8_step
    import rvv_backend_div_pkg::*;
(
    input  logic [DIV8_W:0]   rem_in,
    input  logic              dividend_bit,
    input  logic [DIV8_W-1:0] divisor_mag,
    output logic [DIV8_W:0]   rem_out,
    output logic              q_bit
);

    logic [DIV8_W+1:0] shifted;
    logic [DIV8_W+1:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {2'b00, divisor_mag};

    // No borrow on the trial subtract means the quotient bit is set and the difference is kept.
    assign q_bit   = (shifted >= {2'b00, divisor_mag});
    assign rem_out = q_bit ? diff[DIV8_W:0] : shifted[DIV8_W:0];

endmodule

// File: rtl/rvv_backend_div_unit_div8.sv
// Iterative 8-bit signed/unsigned divider with valid/ready handshakes and flush.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   CALC  | iterating on operand magnitudes, cnt counts remaining cycles down
//   DONE  | result presented on out_valid until out_ready
module rvv_backend_div_unit_div8
    import rvv_backend_div_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIV8_W-1:0] dividend,
    input  logic              dividend_is_signed,
    input  logic [DIV8_W-1:0] divisor,
    input  logic              divisor_is_signed,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIV8_W-1:0] quotient,
    output logic [DIV8_W-1:0] remainder
);

    localparam int         N        = DIV8_W / BITS_PER_CYCLE;
    localparam logic [3:0] CNT_LAST = 4'(N - 1);

    div_state_e        state, state_nxt;
    div8_req_t         req;
    logic [3:0]        cnt;
    logic [DIV8_W:0]   rem;
    logic [DIV8_W-1:0] dvd, dmag;
    logic              neg_q, neg_r;
    logic              sa, sb, div_zero, ovf, special, accept;
    logic [DIV8_W-1:0] a_mag, b_mag, q_raw, r_raw;

    logic [DIV8_W:0]           rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign req = '{dividend: dividend, dividend_is_signed: dividend_is_signed,
                   divisor: divisor, divisor_is_signed: divisor_is_signed};

    assign rem_chain[0] = rem;

    // Dividend bits are consumed MSB-first; quotient bits fill in from the LSB end of dvd.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        rvv_backend_div_unit_div8_step u_step (
            .rem_in       (rem_chain[i]),
            .dividend_bit (dvd[DIV8_W-1-i]),
            .divisor_mag  (dmag),
            .rem_out      (rem_chain[i+1]),
            .q_bit        (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    assign q_raw = (dvd << BITS_PER_CYCLE) | DIV8_W'(q_bits);
    assign r_raw = rem_chain[BITS_PER_CYCLE][DIV8_W-1:0];

    always_comb begin
        sa        = req.dividend_is_signed & req.dividend[DIV8_W-1];
        sb        = req.divisor_is_signed & req.divisor[DIV8_W-1];
        a_mag     = sa ? (~req.dividend + 8'd1) : req.dividend;
        b_mag     = sb ? (~req.divisor + 8'd1) : req.divisor;
        div_zero  = (req.divisor == 8'h00);
        ovf       = req.dividend_is_signed & req.divisor_is_signed &
                    (req.dividend == 8'h80) & (req.divisor == 8'hFF);
        special   = div_zero | ovf;
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        accept    = in_valid & in_ready & ~flush;
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == 4'd0) state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    if (accept) state_nxt = special ? DONE : CALC;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            rem       <= '0;
            dvd       <= '0;
            dmag      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                rem   <= '0;
                dvd   <= a_mag;
                dmag  <= b_mag;
                neg_q <= sa ^ sb;
                neg_r <= sa;
                cnt   <= CNT_LAST;
                if (special) begin
                    out_valid <= 1'b1;
                    quotient  <= div_zero ? 8'hFF : 8'h80;
                    remainder <= div_zero ? req.dividend : 8'h00;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (state == CALC) begin
                rem <= rem_chain[BITS_PER_CYCLE];
                dvd <= q_raw;
                cnt <= cnt - 4'd1;
                if (cnt == 4'd0) begin
                    out_valid <= 1'b1;
                    quotient  <= neg_q ? (~q_raw + 8'd1) : q_raw;
                    remainder <= neg_r ? (~r_raw + 8'd1) : r_raw;
                end
            end else if ((state == DONE) & out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvv_backend_div_unit_div8.sv
// Self-checking bench for the SEW=8 divider against an arithmetic reference model.
module tb_rvv_backend_div_unit_div8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic       dividend_is_signed;
    logic [7:0] divisor;
    logic       divisor_is_signed;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;

    int n_pass  = 0;
    int n_total = 0;

    rvv_backend_div_unit_div8 #(.BITS_PER_CYCLE(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .dividend           (dividend),
        .dividend_is_signed (dividend_is_signed),
        .divisor            (divisor),
        .divisor_is_signed  (divisor_is_signed),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .quotient           (quotient),
        .remainder          (remainder)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RISC-V division semantics computed with plain integer arithmetic.
    function automatic void model(input logic [7:0] a, input logic as_, input logic [7:0] b,
                                  input logic bs_, output logic [7:0] q, output logic [7:0] r,
                                  output int lat);
        int ia, ib;
        ia = as_ ? int'($signed(a)) : int'(a);
        ib = bs_ ? int'($signed(b)) : int'(b);
        if (ib == 0) begin
            q = 8'hFF; r = a; lat = 1;
        end else if (ia == -128 && ib == -1) begin
            q = 8'h80; r = 8'h00; lat = 1;
        end else begin
            q = 8'(ia / ib); r = 8'(ia % ib); lat = 9;
        end
    endfunction

    task automatic run_op(input logic [7:0] a, input logic as_, input logic [7:0] b,
                          input logic bs_, output logic [7:0] q, output logic [7:0] r,
                          output int lat);
        int w;
        @(negedge clk);
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        dividend = a; dividend_is_signed = as_;
        divisor  = b; divisor_is_signed  = bs_;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (quotient !== 8'h00) $display("FAIL reset quotient: got %h expected 00", quotient); else n_pass++;
        n_total++; if (remainder !== 8'h00) $display("FAIL reset remainder: got %h expected 00", remainder); else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] ta [6];
        logic       tas [6];
        logic [7:0] tb [6];
        logic       tbs [6];
        logic [7:0] eq [6];
        logic [7:0] er [6];
        int         el [6];
        logic [7:0] q, r;
        int         lat;
        ta  = '{8'd100, 8'h9C, 8'h80, 8'h37, 8'h80, 8'd255};
        tas = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
        tb  = '{8'd7,   8'h07, 8'hFF, 8'h00, 8'hFF, 8'd16};
        tbs = '{1'b0,   1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        eq  = '{8'd14,  8'hF2, 8'h00, 8'hFF, 8'h80, 8'd15};
        er  = '{8'd2,   8'hFE, 8'h80, 8'h37, 8'h00, 8'd15};
        el  = '{9,      9,     9,     1,     1,     9};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tas[i], tb[i], tbs[i], q, r, lat);
            n_total++; if (q !== eq[i]) $display("FAIL directed[%0d] quotient: got %h expected %h", i, q, eq[i]); else n_pass++;
            n_total++; if (r !== er[i]) $display("FAIL directed[%0d] remainder: got %h expected %h", i, r, er[i]); else n_pass++;
            n_total++; if (lat != el[i]) $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, el[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, q, r, mq, mr;
        logic       as_, bs_;
        int         lat, mlat, mode;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            as_ = 1'($urandom); bs_ = 1'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 8'h00;
            else if (mode == 1) begin a = 8'h80; b = 8'hFF; end
            model(a, as_, b, bs_, mq, mr, mlat);
            run_op(a, as_, b, bs_, q, r, lat);
            n_total++; if (q !== mq) $display("FAIL random[%0d] quotient %h/%h s%b%b: got %h expected %h", i, a, b, as_, bs_, q, mq); else n_pass++;
            n_total++; if (r !== mr) $display("FAIL random[%0d] remainder %h/%h s%b%b: got %h expected %h", i, a, b, as_, bs_, r, mr); else n_pass++;
            n_total++; if (lat != mlat) $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, mlat); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] mq, mr;
        int         mlat, w;
        model(8'd200, 1'b0, 8'd9, 1'b0, mq, mr, mlat);
        @(negedge clk);
        out_ready = 1'b0;
        dividend = 8'd200; dividend_is_signed = 1'b0;
        divisor  = 8'd9;   divisor_is_signed  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        w = 1;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_total++; if (w != mlat) $display("FAIL backpressure latency: got %0d expected %0d", w, mlat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++; if (out_valid !== 1'b1) $display("FAIL hold[%0d] out_valid: got %b expected 1", i, out_valid); else n_pass++;
            n_total++; if (quotient !== mq) $display("FAIL hold[%0d] quotient: got %h expected %h", i, quotient, mq); else n_pass++;
            n_total++; if (remainder !== mr) $display("FAIL hold[%0d] remainder: got %h expected %h", i, remainder, mr); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL hold[%0d] in_ready: got %b expected 0", i, in_ready); else n_pass++;
        end
    endtask

    // Entered with a result held in DONE and out_ready low.
    task automatic test_back_to_back();
        logic [7:0] a, b, mq, mr;
        logic       as_;
        int         mlat, w;
        a = 8'($urandom); b = 8'($urandom_range(1, 127)); as_ = 1'($urandom);
        model(a, as_, b, 1'b1, mq, mr, mlat);
        out_ready = 1'b1;
        dividend = a; dividend_is_signed = as_;
        divisor  = b; divisor_is_signed  = 1'b1;
        in_valid = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL b2b in_ready: got %b expected 1", in_ready); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b out_valid after accept: got %b expected 0", out_valid); else n_pass++;
        w = 1;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_total++; if (w != mlat) $display("FAIL b2b latency: got %0d expected %0d", w, mlat); else n_pass++;
        n_total++; if (quotient !== mq) $display("FAIL b2b quotient %h/%h: got %h expected %h", a, b, quotient, mq); else n_pass++;
        n_total++; if (remainder !== mr) $display("FAIL b2b remainder %h/%h: got %h expected %h", a, b, remainder, mr); else n_pass++;
        // DONE to DONE: a divide-by-zero accepted while the previous result drains.
        a = 8'($urandom);
        dividend = a; dividend_is_signed = 1'b0;
        divisor  = 8'h00; divisor_is_signed = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL b2b special out_valid: got %b expected 1", out_valid); else n_pass++;
        n_total++; if (quotient !== 8'hFF) $display("FAIL b2b special quotient: got %h expected ff", quotient); else n_pass++;
        n_total++; if (remainder !== a) $display("FAIL b2b special remainder: got %h expected %h", remainder, a); else n_pass++;
    endtask

    task automatic test_flush();
        logic [7:0] q, r;
        int         lat, seen;
        @(negedge clk);
        out_ready = 1'b1;
        dividend = 8'd200; dividend_is_signed = 1'b0;
        divisor  = 8'd3;   divisor_is_signed  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        dividend = 8'h37; divisor = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush in_ready: got %b expected 1", in_ready); else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL flush stray out_valid cycles: got %0d expected 0", seen); else n_pass++;
        run_op(8'd255, 1'b0, 8'd16, 1'b0, q, r, lat);
        n_total++; if (q !== 8'd15) $display("FAIL post-flush quotient: got %0d expected 15", q); else n_pass++;
        n_total++; if (r !== 8'd15) $display("FAIL post-flush remainder: got %0d expected 15", r); else n_pass++;
        n_total++; if (lat != 9) $display("FAIL post-flush latency: got %0d expected 9", lat); else n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        @(negedge clk);
        out_ready = 1'b1;
        dividend = 8'd100; dividend_is_signed = 1'b0;
        divisor  = 8'd7;   divisor_is_signed  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midreset out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (quotient !== 8'h00) $display("FAIL midreset quotient: got %h expected 00", quotient); else n_pass++;
        n_total++; if (remainder !== 8'h00) $display("FAIL midreset remainder: got %h expected 00", remainder); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midreset in_ready: got %b expected 1", in_ready); else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL midreset stray out_valid cycles: got %0d expected 0", seen); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        dividend = 8'h00; dividend_is_signed = 1'b0;
        divisor  = 8'h00; divisor_is_signed  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
